// File: rtl/peripheral_msi_arbiter_apb4_if.sv
// Request/grant bundle between the masters of the MSI interconnect and one slave-port arbiter.
// Semantics: a master requests while mst_HSEL is high and mst_HTRANS is not IDLE; ownership only moves in a cycle with slv_HREADY high.
interface peripheral_msi_arbiter_apb4_if #(
  parameter int MASTERS = 5
);
  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0]   mst_HSEL;
  logic [2*MASTERS-1:0] mst_HTRANS;
  logic [3*MASTERS-1:0] mst_priority;
  logic [MASTERS-1:0]   mst_HMASTLOCK;
  logic [MASTERS-1:0]   can_switch;
  logic                 slv_HREADY;
  logic [MASTERS-1:0]   granted_master;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_change;

  // Requesting side: masters plus the slave's ready.
  modport master (
    output mst_HSEL, mst_HTRANS, mst_priority, mst_HMASTLOCK, can_switch, slv_HREADY,
    input  granted_master, grant_idx, grant_change
  );

  // Arbiter side.
  modport slave (
    input  mst_HSEL, mst_HTRANS, mst_priority, mst_HMASTLOCK, can_switch, slv_HREADY,
    output granted_master, grant_idx, grant_change
  );
endinterface

// File: rtl/peripheral_msi_arbiter_apb4.sv
// Per-slave-port MSI arbiter: 3-bit priority with round-robin among equals, switching only at safe points.
// Optional starvation promotion is built when MSI_ARB_STARVATION_EN is defined.
module peripheral_msi_arbiter_apb4 #(
  parameter int MASTERS = 5,
  parameter int TIMEOUT = 15
) (
  input logic HCLK,
  input logic HRESET,
  peripheral_msi_arbiter_apb4_if.slave bus
);
  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0] req;
  logic [3:0]         eff_prio [MASTERS];
  logic [3:0]         max_prio;
  logic               any_req;
  logic               window;
  logic               load;
  logic               found;
  logic [IDX_W-1:0]   pick_idx;

  logic [IDX_W-1:0]   own_idx;
  logic [MASTERS-1:0] own_onehot;
  logic               change_q;
  logic [IDX_W-1:0]   rr_ptr;

`ifdef MSI_ARB_STARVATION_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt [MASTERS];
`endif

  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      req[m]      = bus.mst_HSEL[m] & (bus.mst_HTRANS[2*m +: 2] != 2'b00);
      eff_prio[m] = {1'b0, bus.mst_priority[3*m +: 3]};
`ifdef MSI_ARB_STARVATION_EN
      // A starved master outranks every normal priority level.
      if (wait_cnt[m] == WAIT_MAX) eff_prio[m] = 4'd8;
`endif
    end
  end

  always_comb begin
    any_req  = |req;
    max_prio = 4'd0;
    for (int m = 0; m < MASTERS; m++) begin
      if (req[m] && (eff_prio[m] > max_prio)) max_prio = eff_prio[m];
    end
  end

  // Search starts just after the pointer and wraps, so the owner competes last among equals.
  always_comb begin
    int idx;
    pick_idx = own_idx;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MASTERS) idx = idx - MASTERS;
      if (!found && req[idx] && (eff_prio[idx] == max_prio)) begin
        pick_idx = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // A locked owner that still requests can never be preempted.
  assign window = bus.slv_HREADY &
                  (~req[own_idx] | (bus.can_switch[own_idx] & ~bus.mst_HMASTLOCK[own_idx]));
  assign load   = window & any_req;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      own_idx    <= '0;
      own_onehot <= MASTERS'(1);
      change_q   <= 1'b0;
      rr_ptr     <= '0;
    end else if (load) begin
      own_idx    <= pick_idx;
      own_onehot <= MASTERS'(1) << pick_idx;
      change_q   <= (pick_idx != own_idx);
      rr_ptr     <= pick_idx;
    end else begin
      change_q   <= 1'b0;
    end
  end

`ifdef MSI_ARB_STARVATION_EN
  always_ff @(posedge HCLK) begin
    for (int m = 0; m < MASTERS; m++) begin
      if (HRESET) begin
        wait_cnt[m] <= '0;
      end else if (!req[m] || (own_idx == IDX_W'(m)) || (load && (pick_idx == IDX_W'(m)))) begin
        wait_cnt[m] <= '0;
      end else if (wait_cnt[m] != WAIT_MAX) begin
        wait_cnt[m] <= wait_cnt[m] + WAIT_W'(1);
      end
    end
  end
`endif

  assign bus.granted_master = own_onehot;
  assign bus.grant_idx      = own_idx;
  assign bus.grant_change   = change_q;
endmodule

// File: tb/tb_peripheral_msi_arbiter_apb4.sv
// Directed bench for the MSI slave-port arbiter with MASTERS=4, TIMEOUT=4.
module tb_peripheral_msi_arbiter_apb4;
  localparam int MASTERS = 4;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  peripheral_msi_arbiter_apb4_if #(.MASTERS(MASTERS)) bus ();

  peripheral_msi_arbiter_apb4 #(.MASTERS(MASTERS), .TIMEOUT(TIMEOUT)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] oh, input logic [1:0] idx,
                             input logic chg);
    check({tag, "_onehot"}, 32'(bus.granted_master), 32'(oh));
    check({tag, "_idx"},    32'(bus.grant_idx),      32'(idx));
    check({tag, "_change"}, 32'(bus.grant_change),   32'(chg));
  endtask

  // Driver tasks
  task automatic clear_all();
    bus.mst_HSEL      = '0;
    bus.mst_HTRANS    = '0;
    bus.mst_priority  = '0;
    bus.mst_HMASTLOCK = '0;
    bus.can_switch    = '1;
    bus.slv_HREADY    = 1'b1;
  endtask

  task automatic set_req(input int m, input logic on, input logic [2:0] prio, input logic lock);
    bus.mst_HSEL[m]          = on;
    bus.mst_HTRANS[2*m +: 2] = on ? 2'b10 : 2'b00;
    bus.mst_priority[3*m +: 3] = prio;
    bus.mst_HMASTLOCK[m]     = lock;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rr_oh  [5];
  logic [1:0] rr_idx [5];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_all();

    // 1. Reset
    do_reset();
    check_grant("reset", 4'b0001, 2'd0, 1'b0);

    // 2. Priority: m3 (prio 5) beats m1 (prio 2) while the owner m0 is idle
    set_req(1, 1'b1, 3'd2, 1'b0);
    set_req(3, 1'b1, 3'd5, 1'b0);
    tick();
    check_grant("prio", 4'b1000, 2'd3, 1'b1);
    tick();
    check_grant("prio_hold", 4'b1000, 2'd3, 1'b0);

    // 3. Round-robin among four equal-priority requesters, pointer starts at 0 after reset
    clear_all();
    for (int m = 0; m < MASTERS; m++) set_req(m, 1'b1, 3'd3, 1'b0);
    do_reset();
    rr_oh[0] = 4'b0010; rr_idx[0] = 2'd1;
    rr_oh[1] = 4'b0100; rr_idx[1] = 2'd2;
    rr_oh[2] = 4'b1000; rr_idx[2] = 2'd3;
    rr_oh[3] = 4'b0001; rr_idx[3] = 2'd0;
    rr_oh[4] = 4'b0010; rr_idx[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant($sformatf("rr%0d", i), rr_oh[i], rr_idx[i], 1'b1);
    end

    // 4. Lock and ready hold
    clear_all();
    set_req(2, 1'b1, 3'd0, 1'b1);
    tick();
    check_grant("lock_take", 4'b0100, 2'd2, 1'b1);
    set_req(0, 1'b1, 3'd7, 1'b0);
    tick();
    check_grant("lock_hold", 4'b0100, 2'd2, 1'b0);
    bus.mst_HMASTLOCK[2] = 1'b0;
    bus.slv_HREADY       = 1'b0;
    tick();
    check_grant("wait_hold", 4'b0100, 2'd2, 1'b0);
    bus.mst_priority[3*0 +: 3] = 3'd1;
    bus.mst_priority[3*0 +: 3] = 3'd7;
    bus.slv_HREADY       = 1'b1;
    tick();
    check_grant("lock_release", 4'b0001, 2'd0, 1'b1);

    // 5. Parking on the last owner
    clear_all();
    set_req(3, 1'b1, 3'd1, 1'b0);
    tick();
    check_grant("park_take", 4'b1000, 2'd3, 1'b1);
    clear_all();
    tick();
    check_grant("park0", 4'b1000, 2'd3, 1'b0);
    tick();
    check_grant("park1", 4'b1000, 2'd3, 1'b0);

    // 6. Starvation: m0 prio 7 streams, m1 prio 0 waits
    set_req(0, 1'b1, 3'd7, 1'b0);
    tick();
    check_grant("starve_own", 4'b0001, 2'd0, 1'b1);
    set_req(1, 1'b1, 3'd0, 1'b0);
`ifdef MSI_ARB_STARVATION_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check_grant($sformatf("starve_wait%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    check_grant("starve_promote", 4'b0010, 2'd1, 1'b1);
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      check_grant($sformatf("no_starve%0d", i), 4'b0001, 2'd0, 1'b0);
    end
`endif

    // Reset asserted mid-transfer with a locked owner and HREADY low
    set_req(1, 1'b0, 3'd0, 1'b0);
    set_req(2, 1'b1, 3'd7, 1'b1);
    tick();
    check_grant("pre_reset", 4'b0100, 2'd2, 1'b1);
    bus.slv_HREADY = 1'b0;
    rst = 1'b1;
    tick();
    check_grant("mid_reset", 4'b0001, 2'd0, 1'b0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
